// File: rtl/sent_pkg.sv
// rtl/sent_pkg.sv - SENT TX shared types, timing constants and CRC step
package sent_pkg;

  typedef enum logic [1:0] {
    NIB_SYNC  = 2'd0,
    NIB_DATA  = 2'd1,
    NIB_PAUSE = 2'd2
  } nib_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_STATUS,
    ST_DATA,
    ST_CRC,
    ST_PAUSE,
    ST_DONE
  } tx_state_e;

  localparam logic [15:0] SYNC_TICKS        = 16'd56;
  localparam logic [15:0] NIBBLE_BASE_TICKS = 16'd12;
  localparam logic [15:0] MIN_PAUSE_TICKS   = 16'd12;
  localparam logic [3:0]  CRC_SEED          = 4'h5;
  localparam logic [3:0]  CRC_POLY          = 4'b1101;

  // One nibble through the 4-bit SENT CRC, MSB first.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic [3:0] nib);
    logic [3:0] c;
    logic       fb;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      fb = c[3] ^ nib[i];
      c  = {c[2:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  function automatic logic [15:0] nibble_ticks(input logic [3:0] value);
    return NIBBLE_BASE_TICKS + {12'd0, value};
  endfunction

  // Pause that pads the frame to frame_ticks, never shorter than the minimum.
  function automatic logic [15:0] pause_len(input logic [15:0] frame_ticks, input logic [8:0] acc);
    logic [16:0] need;
    need = {8'd0, acc} + {1'b0, MIN_PAUSE_TICKS};
    if ({1'b0, frame_ticks} < need) return MIN_PAUSE_TICKS;
    return frame_ticks - {7'd0, acc};
  endfunction

endpackage

// File: rtl/sent_tx_frame_ctrl_if.sv
// rtl/sent_tx_frame_ctrl_if.sv - pulse descriptor handshake between sequencer and pulse generator
interface sent_tx_frame_ctrl_if;
  logic        nib_valid;
  logic [1:0]  nib_type;
  logic [3:0]  nib_value;
  logic [15:0] nib_ticks;
  logic        nib_ready;

  modport master (output nib_valid, nib_type, nib_value, nib_ticks, input nib_ready);
  modport slave  (input nib_valid, nib_type, nib_value, nib_ticks, output nib_ready);
endinterface

// File: rtl/sent_crc4.sv
// rtl/sent_crc4.sv - registered SENT CRC with seed init, nibble step and augmented result
module sent_crc4
  import sent_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       step,
  input  logic [3:0] nibble,
  output logic [3:0] crc_aug
);

  logic [3:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || init) crc_q <= CRC_SEED;
    else if (step)   crc_q <= crc4_step(crc_q, nibble);
  end

  // The transmitted CRC is the running value pushed through one zero nibble.
  assign crc_aug = crc4_step(crc_q, 4'h0);

endmodule

// File: rtl/sent_tx_frame_ctrl.sv
// rtl/sent_tx_frame_ctrl.sv - SENT TX frame sequencer emitting pulse descriptors per FIFO word
module sent_tx_frame_ctrl
  import sent_pkg::*;
#(
  parameter int DATAWIDTH    = 24,
  parameter int DATA_NIBBLES = 6
) (
  input  logic                  clk_tx,
  input  logic                  reset_tx,
  input  logic                  enable,
  input  logic [3:0]            status_nibble,
  input  logic                  pause_en,
  input  logic [15:0]           frame_ticks,
  input  logic                  fifo_empty,
  input  logic [DATAWIDTH-1:0]  fifo_rdata,
  output logic                  fifo_rd_en,
  sent_tx_frame_ctrl_if.master  nib,
  output logic                  busy,
  output logic                  frame_done,
  output logic [3:0]            crc_out
);

  localparam int DW = 4 * DATA_NIBBLES;

  tx_state_e     state_q, state_d;
  logic [DW-1:0] data_q;
  logic [3:0]    status_q;
  logic [2:0]    idx_q;
  logic [8:0]    acc_q;
  logic [8:0]    acc_next;
  logic [15:0]   pause_ticks_q;
  logic [3:0]    crc_aug;
  logic          accept;
  logic          last_data;

  assign accept    = nib.nib_valid & nib.nib_ready;
  assign acc_next  = acc_q + nib.nib_ticks[8:0];
  assign last_data = (idx_q == 3'(DATA_NIBBLES - 1));

  sent_crc4 u_crc (
    .clk     (clk_tx),
    .rst     (reset_tx),
    .init    (state_q == ST_LOAD),
    .step    ((state_q == ST_DATA) && accept),
    .nibble  (data_q[DW-1 -: 4]),
    .crc_aug (crc_aug)
  );

  always_ff @(posedge clk_tx) begin
    if (reset_tx) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    fifo_rd_en    = 1'b0;
    frame_done    = 1'b0;
    busy          = (state_q != ST_IDLE);
    nib.nib_valid = 1'b0;
    nib.nib_type  = NIB_SYNC;
    nib.nib_value = 4'h0;
    nib.nib_ticks = 16'd0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty && !reset_tx) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_SYNC;
      ST_SYNC: begin
        nib.nib_valid = 1'b1;
        nib.nib_ticks = SYNC_TICKS;
        if (nib.nib_ready) state_d = ST_STATUS;
      end
      ST_STATUS: begin
        nib.nib_valid = 1'b1;
        nib.nib_type  = NIB_DATA;
        nib.nib_value = status_q;
        nib.nib_ticks = nibble_ticks(status_q);
        if (nib.nib_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        nib.nib_valid = 1'b1;
        nib.nib_type  = NIB_DATA;
        nib.nib_value = data_q[DW-1 -: 4];
        nib.nib_ticks = nibble_ticks(data_q[DW-1 -: 4]);
        if (nib.nib_ready && last_data) state_d = ST_CRC;
      end
      ST_CRC: begin
        nib.nib_valid = 1'b1;
        nib.nib_type  = NIB_DATA;
        nib.nib_value = crc_aug;
        nib.nib_ticks = nibble_ticks(crc_aug);
        if (nib.nib_ready) state_d = pause_en ? ST_PAUSE : ST_DONE;
      end
      ST_PAUSE: begin
        nib.nib_valid = 1'b1;
        nib.nib_type  = NIB_PAUSE;
        nib.nib_ticks = pause_ticks_q;
        if (nib.nib_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data nibbles leave from the top of data_q, which shifts left on each accept.
  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      data_q        <= '0;
      status_q      <= 4'h0;
      idx_q         <= 3'd0;
      acc_q         <= 9'd0;
      pause_ticks_q <= MIN_PAUSE_TICKS;
      crc_out       <= 4'h0;
    end else begin
      if (state_q == ST_LOAD) begin
        data_q   <= fifo_rdata[DW-1:0];
        status_q <= status_nibble;
        idx_q    <= 3'd0;
        acc_q    <= 9'd0;
      end
      if (accept) acc_q <= acc_next;
      if (accept && state_q == ST_DATA) begin
        data_q <= data_q << 4;
        idx_q  <= idx_q + 3'd1;
      end
      if (accept && state_q == ST_CRC) begin
        crc_out       <= crc_aug;
        pause_ticks_q <= pause_len(frame_ticks, acc_next);
      end
    end
  end

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// tb/tb_sent_tx_frame_ctrl.sv - scoreboard bench for sent_tx_frame_ctrl
module tb_sent_tx_frame_ctrl;
  import sent_pkg::*;

  typedef struct {
    logic [1:0]  t;
    logic [3:0]  v;
    logic [15:0] k;
    bit          last;
  } desc_t;

  logic        clk_tx = 1'b0;
  logic        reset_tx = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  status_nibble = 4'h0;
  logic        pause_en = 1'b0;
  logic [15:0] frame_ticks = 16'd0;
  logic        fifo_empty = 1'b1;
  logic [23:0] fifo_rdata = 24'h0;
  logic        fifo_rd_en;
  logic        busy;
  logic        frame_done;
  logic [3:0]  crc_out;

  sent_tx_frame_ctrl_if nib_if ();

  sent_tx_frame_ctrl #(.DATAWIDTH(24), .DATA_NIBBLES(6)) dut (
    .clk_tx        (clk_tx),
    .reset_tx      (reset_tx),
    .enable        (enable),
    .status_nibble (status_nibble),
    .pause_en      (pause_en),
    .frame_ticks   (frame_ticks),
    .fifo_empty    (fifo_empty),
    .fifo_rdata    (fifo_rdata),
    .fifo_rd_en    (fifo_rd_en),
    .nib           (nib_if),
    .busy          (busy),
    .frame_done    (frame_done),
    .crc_out       (crc_out)
  );

  always #5 clk_tx = ~clk_tx;

  int checks = 0;
  int errors = 0;
  desc_t exp_q[$];
  logic [3:0] exp_crc[$];
  logic [23:0] fq[$];
  bit rd_seen = 0;
  bit done_due = 0;
  bit bp_mode = 0;
  int rd_count = 0;
  int frames_done = 0;
  int frame_acc = 0;
  logic [15:0] last_pause = 16'd0;

  // CRC as polynomial remainder: seed*x^(L+4) + M*x^8 mod x^4+x^3+x^2+1, L = 24 bits.
  function automatic logic [3:0] crc_ref(input logic [23:0] w);
    logic [63:0] v;
    v = (64'd5 << 28) ^ ({40'd0, w} << 8);
    for (int i = 63; i >= 4; i--)
      if (v[i]) v = v ^ (64'h1D << (i - 4));
    return v[3:0];
  endfunction

  task automatic push_desc(input logic [1:0] t, input int v, input int k, input bit last);
    desc_t d;
    d.t = t; d.v = 4'(v); d.k = 16'(k); d.last = last;
    exp_q.push_back(d);
  endtask

  task automatic enqueue(input logic [23:0] w);
    int total;
    int c;
    int n;
    int pt;
    c = int'(crc_ref(w));
    total = 56;
    push_desc(NIB_SYNC, 0, 56, 0);
    push_desc(NIB_DATA, int'(status_nibble), 12 + int'(status_nibble), 0);
    total += 12 + int'(status_nibble);
    for (int i = 0; i < 6; i++) begin
      n = int'(w[4*(5-i) +: 4]);
      push_desc(NIB_DATA, n, 12 + n, 0);
      total += 12 + n;
    end
    push_desc(NIB_DATA, c, 12 + c, !pause_en);
    total += 12 + c;
    if (pause_en) begin
      pt = (int'(frame_ticks) < total + 12) ? 12 : int'(frame_ticks) - total;
      push_desc(NIB_PAUSE, 0, pt, 1);
    end
    exp_crc.push_back(4'(c));
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 5000) begin
      @(posedge clk_tx);
      n++;
    end
    #1;
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL frame_timeout got %0d frames need %0d", frames_done, target);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  // FIFO model: pop one word after the edge that saw fifo_rd_en.
  always @(posedge clk_tx) begin
    #1;
    if (rd_seen) begin
      rd_seen = 0;
      if (fq.size() > 0) fifo_rdata = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
  end

  always @(posedge clk_tx) begin
    #1;
    if (bp_mode) nib_if.nib_ready = ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk_tx) begin : monitor
    desc_t e;
    if (reset_tx) begin
      done_due  = 0;
      frame_acc = 0;
      checks++;
      if (fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL rd_en_in_reset got %0b expected 0", fifo_rd_en);
      end
    end else begin
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty || fq.size() == 0) begin
          errors++;
          $display("FAIL rd_en_when_empty got 1 expected 0");
        end
        rd_count++;
        rd_seen = 1;
      end
      checks++;
      if (frame_done !== done_due) begin
        errors++;
        $display("FAIL frame_done got %0b expected %0b", frame_done, done_due);
      end
      if (frame_done) begin
        frames_done++;
        checks++;
        if (exp_crc.size() == 0) begin
          errors++;
          $display("FAIL crc_out unexpected frame got %0h", crc_out);
        end else if (crc_out !== exp_crc.pop_front()) begin
          errors++;
          $display("FAIL crc_out got %0h", crc_out);
        end
      end
      done_due = 0;
      if (nib_if.nib_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL desc unexpected t=%0d v=%0d k=%0d", nib_if.nib_type, nib_if.nib_value, nib_if.nib_ticks);
        end else begin
          e = exp_q[0];
          if (nib_if.nib_type !== e.t || nib_if.nib_value !== e.v || nib_if.nib_ticks !== e.k) begin
            errors++;
            $display("FAIL desc got t=%0d v=%0d k=%0d expected t=%0d v=%0d k=%0d",
                     nib_if.nib_type, nib_if.nib_value, nib_if.nib_ticks, e.t, e.v, e.k);
          end
          if (nib_if.nib_ready) begin
            void'(exp_q.pop_front());
            frame_acc++;
            if (e.t == NIB_PAUSE) last_pause = nib_if.nib_ticks;
            if (e.last) begin
              done_due  = 1;
              frame_acc = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    nib_if.nib_ready = 1'b1;

    // Reset held with a word pending and enable high
    enqueue(24'h000001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_tx);
      checks++;
      if ({fifo_rd_en, nib_if.nib_valid, busy, frame_done, crc_out, nib_if.nib_ticks} !== 24'd0) begin
        errors++;
        $display("FAIL reset_outputs got %0h expected 0",
                 {fifo_rd_en, nib_if.nib_valid, busy, frame_done, crc_out, nib_if.nib_ticks});
      end
    end
    @(posedge clk_tx); #1;
    reset_tx = 1'b0;
    @(negedge clk_tx);
    check_val("first_rd_en", int'(fifo_rd_en), 1);
    wait_frames(1);
    check_val("single_crc", int'(crc_out), 7);
    check_val("single_rd_count", rd_count, 1);

    // Pause padding and minimum pause
    pause_en = 1'b1;
    frame_ticks = 16'd282;
    enqueue(24'h000001);
    wait_frames(2);
    check_val("pause_122", int'(last_pause), 122);
    frame_ticks = 16'd100;
    enqueue(24'h000001);
    wait_frames(3);
    check_val("pause_min", int'(last_pause), 12);

    // Random words, config and backpressure
    bp_mode = 1;
    for (int f = 0; f < 12; f++) begin
      status_nibble = 4'($urandom_range(0, 15));
      pause_en = 1'($urandom_range(0, 1));
      frame_ticks = 16'($urandom_range(150, 400));
      base = frames_done;
      enqueue(24'($urandom()));
      if (f % 3 == 0) enqueue(24'($urandom()));
      wait_frames(base + ((f % 3 == 0) ? 2 : 1));
    end
    @(posedge clk_tx); #1;
    bp_mode = 0;
    nib_if.nib_ready = 1'b1;
    pause_en = 1'b0;
    status_nibble = 4'h0;

    // Enable dropped during DATA of the first of three queued frames
    enable = 1'b0;
    base = rd_count;
    n = frames_done;
    enqueue(24'h123456);
    enqueue(24'hABCDEF);
    enqueue(24'h0F0F0F);
    @(posedge clk_tx); #1;
    enable = 1'b1;
    for (int i = 0; i < 200 && frame_acc < 3; i++) @(posedge clk_tx);
    #1;
    enable = 1'b0;
    wait_frames(n + 1);
    repeat (10) @(negedge clk_tx);
    check_val("enable_off_busy", int'(busy), 0);
    check_val("enable_off_rd_count", rd_count, base + 1);
    @(posedge clk_tx); #1;
    enable = 1'b1;
    wait_frames(n + 3);
    repeat (10) @(negedge clk_tx);
    check_val("empty_busy", int'(busy), 0);
    check_val("empty_rd_count", rd_count, base + 3);

    // Reset while data nibble 3 is presented
    n = frames_done;
    enqueue(24'h9A5C31);
    for (int i = 0; i < 200 && frame_acc < 5; i++) begin
      @(posedge clk_tx); #1;
    end
    check_val("reset_at_data3", frame_acc, 5);
    reset_tx = 1'b1;
    exp_q.delete();
    exp_crc.delete();
    @(posedge clk_tx); #1;
    reset_tx = 1'b0;
    @(negedge clk_tx);
    check_val("valid_after_reset", int'(nib_if.nib_valid), 0);
    @(posedge clk_tx); #1;
    enqueue(24'h9A5C31);
    wait_frames(n + 1);
    check_val("crc_after_reset", int'(crc_out), int'(crc_ref(24'h9A5C31)));

    repeat (5) @(posedge clk_tx);
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
